// File: rtl/buffer_loader_pkg.sv
// Shared defines (data width, buffer address width, FSM encodings) and loader package.
// Optional feature macro used by this slice: BUFFER_LOADER_WRAP_EN.
`ifndef BUFFER_LOADER_DEFINES_SVH
`define BUFFER_LOADER_DEFINES_SVH
`define CNN_XLEN 16
`define ADDR_B 4
`define BL_STATE_IDLE 2'd0
`define BL_STATE_LOAD 2'd1
`define BL_STATE_DONE 2'd2
`endif

package buffer_loader_pkg;
   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] IDLE = `BL_STATE_IDLE;
   localparam logic [STATE_W-1:0] LOAD = `BL_STATE_LOAD;
   localparam logic [STATE_W-1:0] DONE = `BL_STATE_DONE;
endpackage

// File: rtl/loader_addr_gen.sv
// Buffer write-address counter with end-of-buffer overflow detection.
// BUFFER_LOADER_WRAP_EN: address wraps freely and no job is ever flagged as overflowing.
module loader_addr_gen #(
   parameter int unsigned ADDR_B = `ADDR_B
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_B-1:0] base_addr,
   input  logic [ADDR_B-1:0] len_m1,
   output logic [ADDR_B-1:0] addr,
   output logic              overflow_c
);
   import buffer_loader_pkg::*;

   always_ff @(posedge clk) begin
      if (reset)
         addr <= '0;
      else if (load)
         addr <= base_addr;
      else if (step)
         addr <= addr + ADDR_B'(1);
   end

`ifdef BUFFER_LOADER_WRAP_EN
   assign overflow_c = 1'b0;
`else
   // Carry out of the last-address sum means the job runs past the top of the buffer.
   logic [ADDR_B:0] last_addr;
   assign last_addr  = {1'b0, base_addr} + {1'b0, len_m1};
   assign overflow_c = last_addr[ADDR_B];
`endif
endmodule

// File: rtl/buffer_loader.sv
// Streams a fixed-length burst of words into a buffer starting at a programmable address.
// BUFFER_LOADER_WRAP_EN: address wraps at the buffer top and every start is accepted.
module buffer_loader #(
   parameter int unsigned DATA_WID = `CNN_XLEN,
   parameter int unsigned ADDR_B   = `ADDR_B
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [ADDR_B-1:0]          base_addr,
   input  logic [ADDR_B-1:0]          len_m1,
   input  logic signed [DATA_WID-1:0] in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic                       wrb,
   output logic [ADDR_B-1:0]          wrb_addr,
   output logic signed [DATA_WID-1:0] wrb_data,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);
   import buffer_loader_pkg::*;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic [ADDR_B-1:0]  beat_cnt;
   logic [ADDR_B-1:0]  addr;
   logic               overflow_c;
   logic               launch;
   logic               reject;
   logic               accept;
   logic               last_beat;

   loader_addr_gen #(
      .ADDR_B (ADDR_B)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (launch),
      .step       (accept),
      .base_addr  (base_addr),
      .len_m1     (len_m1),
      .addr       (addr),
      .overflow_c (overflow_c)
   );

   assign in_ready  = (state == LOAD);
   assign busy      = (state != IDLE);
   assign accept    = in_ready && in_valid;
   assign last_beat = accept && (beat_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      reject    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (overflow_c) begin
                  reject = 1'b1;
               end else begin
                  launch    = 1'b1;
                  state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            if (last_beat)
               state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Write port is a one-cycle registered copy of each accepted beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrb      <= 1'b0;
         wrb_addr <= '0;
         wrb_data <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         beat_cnt <= '0;
      end else begin
         wrb  <= accept;
         done <= last_beat;
         err  <= reject;
         if (accept) begin
            wrb_addr <= addr;
            wrb_data <= in_data;
         end
         if (launch)
            beat_cnt <= len_m1;
         else if (accept)
            beat_cnt <= beat_cnt - ADDR_B'(1);
      end
   end
endmodule

// File: tb/tb_buffer_loader.sv
// Directed self-checking bench for buffer_loader at ADDR_B=4, DATA_WID=16.
module tb_buffer_loader;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [AW-1:0]        base_addr;
   logic [AW-1:0]        len_m1;
   logic signed [DW-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 wrb;
   logic [AW-1:0]        wrb_addr;
   logic signed [DW-1:0] wrb_data;
   logic                 busy;
   logic                 done;
   logic                 err;

   int checks = 0;
   int errors = 0;

   buffer_loader #(.DATA_WID(DW), .ADDR_B(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .len_m1    (len_m1),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wrb       (wrb),
      .wrb_addr  (wrb_addr),
      .wrb_data  (wrb_data),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Write log captured mid-cycle, away from the active edge.
   int                   cyc = 0;
   logic [AW-1:0]        wa_q[$];
   logic signed [DW-1:0] wd_q[$];
   bit                   wdn_q[$];
   int                   wc_q[$];
   int                   done_cnt = 0;
   int                   err_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wrb) begin
         wa_q.push_back(wrb_addr);
         wd_q.push_back(wrb_data);
         wdn_q.push_back(done);
         wc_q.push_back(cyc);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (err)  err_cnt  <= err_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] l);
      base_addr = b;
      len_m1    = l;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic beat(input logic signed [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic settle(input string name);
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s settle: busy still 1 after %0d cycles, required 0", name, n);
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      start = 1'b0; base_addr = '0; len_m1 = '0; in_data = '0; in_valid = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({wrb, done, err, in_ready, busy} !== 5'b0) begin
         errors++;
         $display("FAIL reset ctl: wrb/done/err/in_ready/busy = %b, required 00000",
                  {wrb, done, err, in_ready, busy});
      end
      checks++;
      if (wrb_addr !== 4'd0 || wrb_data !== 16'sd0) begin
         errors++;
         $display("FAIL reset data: addr=%0d data=%0d, required 0/0", wrb_addr, wrb_data);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int b0 = wa_q.size();
      int d0 = done_cnt;
      launch(4'd3, 4'd3);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic load: in_ready=%b busy=%b, required 1/1", in_ready, busy);
      end
      for (int i = 0; i < 4; i++) beat(16'(10 + i));
      settle("basic");
      checks++;
      if (wa_q.size() - b0 != 4) begin
         errors++;
         $display("FAIL basic count: %0d writes, required 4", wa_q.size() - b0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[b0+i] !== 4'(3 + i) || wd_q[b0+i] !== 16'(10 + i) || wdn_q[b0+i] !== (i == 3)
                || wc_q[b0+i] - wc_q[b0] != i) begin
               errors++;
               $display("FAIL basic w%0d: addr=%0d data=%0d done=%b dcyc=%0d, required %0d/%0d/%b/%0d",
                        i, wa_q[b0+i], wd_q[b0+i], wdn_q[b0+i], wc_q[b0+i] - wc_q[b0],
                        3 + i, 10 + i, i == 3, i);
            end
         end
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL basic done: %0d pulses, required 1", done_cnt - d0);
      end
   endtask

   task automatic test_stall();
      int b0 = wa_q.size();
      launch(4'd3, 4'd3);
      beat(16'sd10);
      beat(16'sd11);
      for (int g = 0; g < 2; g++) begin
         tick();
         checks++;
         if (wrb !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall gap%0d: wrb=%b in_ready=%b, required 0/1", g, wrb, in_ready);
         end
      end
      beat(16'sd12);
      beat(16'sd13);
      settle("stall");
      checks++;
      if (wa_q.size() - b0 != 4) begin
         errors++;
         $display("FAIL stall count: %0d writes, required 4", wa_q.size() - b0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[b0+i] !== 4'(3 + i) || wd_q[b0+i] !== 16'(10 + i)) begin
               errors++;
               $display("FAIL stall w%0d: addr=%0d data=%0d, required %0d/%0d",
                        i, wa_q[b0+i], wd_q[b0+i], 3 + i, 10 + i);
            end
         end
      end
   endtask

   task automatic test_boundary();
      int b0 = wa_q.size();
      int e0 = err_cnt;
`ifdef BUFFER_LOADER_WRAP_EN
      logic [AW-1:0] exp_a[4];
      exp_a[0] = 4'd14; exp_a[1] = 4'd15; exp_a[2] = 4'd0; exp_a[3] = 4'd1;
      launch(4'd14, 4'd3);
      for (int i = 0; i < 4; i++) beat(16'(-5 - i));
      settle("wrap");
      checks++;
      if (wa_q.size() - b0 != 4 || err_cnt != e0) begin
         errors++;
         $display("FAIL wrap count: %0d writes %0d errs, required 4/0", wa_q.size() - b0, err_cnt - e0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[b0+i] !== exp_a[i] || wd_q[b0+i] !== 16'(-5 - i)) begin
               errors++;
               $display("FAIL wrap w%0d: addr=%0d data=%0d, required %0d/%0d",
                        i, wa_q[b0+i], wd_q[b0+i], exp_a[i], -5 - i);
            end
         end
      end
`else
      launch(4'd14, 4'd3);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reject pulse: err=%b busy=%b in_ready=%b, required 1/0/0", err, busy, in_ready);
      end
      beat(16'sd77);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reject after: err=%b busy=%b, required 0/0", err, busy);
      end
      tick();
      tick();
      checks++;
      if (wa_q.size() != b0 || err_cnt - e0 != 1) begin
         errors++;
         $display("FAIL reject totals: %0d writes %0d errs, required 0/1", wa_q.size() - b0, err_cnt - e0);
      end
`endif
   endtask

   task automatic test_full();
      int b0 = wa_q.size();
      int d0 = done_cnt;
      int bad = 0;
      launch(4'd0, 4'd15);
      for (int i = 0; i < 16; i++) beat(16'(100 + i));
      settle("full");
      checks++;
      if (wa_q.size() - b0 != 16 || done_cnt - d0 != 1) begin
         errors++;
         $display("FAIL full count: %0d writes %0d dones, required 16/1", wa_q.size() - b0, done_cnt - d0);
      end else begin
         for (int i = 0; i < 16; i++)
            if (wa_q[b0+i] !== 4'(i) || wd_q[b0+i] !== 16'(100 + i) || wdn_q[b0+i] !== (i == 15))
               bad++;
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL full content: %0d bad writes, required 0", bad);
         end
      end
   endtask

   task automatic test_reset_mid();
      int b0;
      int d0 = done_cnt;
      launch(4'd3, 4'd3);
      beat(16'sd10);
      beat(16'sd11);
      reset = 1'b1;
      tick();
      checks++;
      if (wrb !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || wrb_addr !== 4'd0) begin
         errors++;
         $display("FAIL midreset: wrb=%b in_ready=%b busy=%b addr=%0d, required 0/0/0/0",
                  wrb, in_ready, busy, wrb_addr);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (done_cnt != d0) begin
         errors++;
         $display("FAIL midreset done: %0d pulses, required 0", done_cnt - d0);
      end
      b0 = wa_q.size();
      launch(4'd3, 4'd3);
      for (int i = 0; i < 4; i++) beat(16'(10 + i));
      settle("rejob");
      checks++;
      if (wa_q.size() - b0 != 4) begin
         errors++;
         $display("FAIL rejob count: %0d writes, required 4", wa_q.size() - b0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[b0+i] !== 4'(3 + i) || wd_q[b0+i] !== 16'(10 + i)) begin
               errors++;
               $display("FAIL rejob w%0d: addr=%0d data=%0d, required %0d/%0d",
                        i, wa_q[b0+i], wd_q[b0+i], 3 + i, 10 + i);
            end
         end
      end
   endtask

   task automatic test_ignored_start();
      int b0 = wa_q.size();
      launch(4'd3, 4'd3);
      beat(16'sd20);
      base_addr = 4'd9;
      len_m1    = 4'd0;
      start     = 1'b1;
      beat(16'sd21);
      start = 1'b0;
      beat(16'sd22);
      beat(16'sd23);
      start = 1'b1;
      tick();
      start = 1'b0;
      settle("ignstart");
      checks++;
      if (wa_q.size() - b0 != 4) begin
         errors++;
         $display("FAIL ignstart count: %0d writes, required 4", wa_q.size() - b0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa_q[b0+i] !== 4'(3 + i) || wd_q[b0+i] !== 16'(20 + i)) begin
               errors++;
               $display("FAIL ignstart w%0d: addr=%0d data=%0d, required %0d/%0d",
                        i, wa_q[b0+i], wd_q[b0+i], 3 + i, 20 + i);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_boundary();
      test_full();
      test_reset_mid();
      test_ignored_start();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/buffer_loader.md
BUFFER_LOADER -- requirements
Module: buffer_loader

Interface
REQ-001 Parameters SHALL be: DATA_WID, default `CNN_XLEN, data word width; ADDR_B, default `ADDR_B, buffer address width, capacity 2^ADDR_B words.
REQ-002 Port clk, input, 1 bit: clock, all state updates on posedge.
REQ-003 Port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 Port start, input, 1 bit: begin a load job, sampled only in IDLE.
REQ-005 Port base_addr, input, ADDR_B bits: first write address, sampled with start.
REQ-006 Port len_m1, input, ADDR_B bits: job length minus one (1..2^ADDR_B words), sampled with start.
REQ-007 Port in_data, input, signed DATA_WID bits: streamed word.
REQ-008 Port in_valid, input, 1 bit: in_data valid.
REQ-009 Port in_ready, output, 1 bit: loader accepts a word this cycle.
REQ-010 Port wrb, output reg, 1 bit: buffer write enable.
REQ-011 Port wrb_addr, output reg, ADDR_B bits: buffer write address.
REQ-012 Port wrb_data, output reg, signed DATA_WID bits: buffer write data.
REQ-013 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 Port done, output reg, 1 bit: one-cycle job completion pulse.
REQ-015 Port err, output reg, 1 bit: one-cycle rejected-start pulse; held 0 when BUFFER_LOADER_WRAP_EN is defined.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and DONE.
REQ-017 IDLE: in_ready=0; start=1 at cycle t SHALL load the address counter with base_addr and the beat counter with len_m1, entering LOAD at t+1.
REQ-018 LOAD: in_ready SHALL be 1; a beat is accepted when in_valid and in_ready are both 1.
REQ-019 For a beat accepted at cycle t, the block SHALL drive wrb=1, wrb_addr=current address and wrb_data=in_data at t+1 (one-cycle registered latency).
REQ-020 wrb SHALL be 0 in every cycle not following an accepted beat; wrb_addr/wrb_data SHALL hold their last values when wrb=0.
REQ-021 After each accepted beat, the address SHALL increment by 1 and the beat counter SHALL decrement by 1.
REQ-022 in_valid=0 in LOAD SHALL stall without writes or counter changes, for any number of cycles.
REQ-023 The beat accepted while the beat counter is 0 SHALL be the last; the state SHALL be DONE at t+1, with done=1 coinciding with the final wrb.
REQ-024 DONE SHALL last exactly one cycle with in_ready=0, then return to IDLE; a start in DONE SHALL be ignored.
REQ-025 start asserted in LOAD or DONE SHALL be ignored with no effect on the running job.
REQ-026 Data SHALL pass unmodified; no arithmetic is performed on in_data.

Reset
REQ-027 reset=1 SHALL force IDLE and clear wrb, wrb_addr, wrb_data, done, err and both counters to 0 on the next posedge, including mid-job; the partial job is abandoned.
REQ-028 During and after reset, in_ready=0 and busy=0.

Configuration
REQ-029 With BUFFER_LOADER_WRAP_EN defined, the address SHALL wrap from 2^ADDR_B-1 to 0 and every start SHALL be accepted.
REQ-030 With BUFFER_LOADER_WRAP_EN undefined, a start where base_addr+len_m1 > 2^ADDR_B-1 SHALL be rejected: err=1 for one cycle at t+1, the FSM stays in IDLE, and no writes occur.

Structure
REQ-031 The FSM state encodings (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) SHALL live in the shared defines header alongside `CNN_XLEN and `ADDR_B.
REQ-032 The address counter, with its wrap/overflow check, SHALL be a sub-module named loader_addr_gen; all other logic SHALL stay in buffer_loader.

Verification (ADDR_B=4, DATA_WID=16)
REQ-033 Basic job: base=3, len_m1=3, in_valid held 1, data 10,11,12,13 -> writes (3,10),(4,11),(5,12),(6,13) on consecutive cycles; done coincides with (6,13).
REQ-034 Stall: same job with in_valid low for 2 cycles after the 2nd beat -> no wrb during the gap; addresses stay 3..6 with no skips or duplicates.
REQ-035 Boundary: base=14, len_m1=3 -> with WRAP_EN, writes to 14,15,0,1; without it, err pulse one cycle after start, no wrb, busy stays 0.
REQ-036 Full buffer: base=0, len_m1=15 -> exactly 16 writes to addresses 0..15, then a single done pulse.
REQ-037 Reset mid-job: reset asserted after the 2nd beat -> next cycle wrb=0, in_ready=0, busy=0; a new start then behaves as in REQ-033.
REQ-038 Ignored start: start pulsed during LOAD with base=9 -> the running job's addresses are unaffected and no extra job runs.
